cloud_scroll_ctrl: RTL and testbench

CLOUD_SCROLL_CTRL -- requirements
Module: cloud_scroll_ctrl

---
 rtl/cloud_scroll_pkg.sv | 26 ++
 rtl/cloud_scroll_ctrl_lfsr8.sv | 21 ++
 rtl/cloud_scroll_ctrl.sv | 135 +++++++++++++
 tb/tb_cloud_scroll_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cloud_scroll_pkg.sv
// Shared definitions for the background scroller: FSM states, reset cloud
// placement, LFSR feedback taps and the default screen width.
package cloud_scroll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UPD0,
    UPD1,
    UPD2,
    DONE
  } state_t;

  localparam int unsigned NUM_CLOUDS       = 3;
  localparam logic [9:0]  SCREEN_W_DEFAULT = 10'd640;

  // Taps 8,6,5,4 counted from 1, i.e. bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic [NUM_CLOUDS-1:0][9:0] CLOUD_RST_X = {10'd500, 10'd100, 10'd10};
  localparam logic [NUM_CLOUDS-1:0][9:0] CLOUD_RST_Y = {10'd80,  10'd100, 10'd10};

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/cloud_scroll_ctrl_lfsr8.sv
// 8-bit Fibonacci LFSR that advances only when step is high; also intended
// for obstacle spawning, so the seed is a port rather than a parameter.
module lfsr8
  import cloud_scroll_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= seed;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/cloud_scroll_ctrl.sv
// Per-frame background updater: walks the three clouds leftwards every
// CLOUD_DIV accepted frames and advances the horizon scroll offset.
module cloud_scroll_ctrl
  import cloud_scroll_pkg::*;
#(
  parameter int unsigned CLOUD_DIV = 4,
  parameter logic [9:0]  SCREEN_W  = SCREEN_W_DEFAULT,
  parameter logic [9:0]  Y_MIN     = 10'd20,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       run,
  input  logic [2:0] speed,
  output logic [9:0] cloud0_x,
  output logic [9:0] cloud1_x,
  output logic [9:0] cloud2_x,
  output logic [9:0] cloud0_y,
  output logic [9:0] cloud1_y,
  output logic [9:0] cloud2_y,
  output logic [9:0] horizon_off,
  output logic       upd_done,
  output logic       missed_tick
);

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        upd_active;
  logic [1:0]  idx;
  logic        upd_done_nxt;
  logic        missed_nxt;

  logic [3:0]  div_cnt;
  logic        move_frame;
  logic [2:0]  speed_q;
  logic [7:0]  lfsr;
  logic [10:0] h_sum;
  logic [10:0] h_wrap;

  logic [9:0]  cx [NUM_CLOUDS];
  logic [9:0]  cy [NUM_CLOUDS];

  assign accept = (state == IDLE) && frame_tick && run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = UPD0;
      UPD0:    state_nxt = UPD1;
      UPD1:    state_nxt = UPD2;
      UPD2:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Each UPD state owns one cloud slot; idx selects it in the arrays.
  always_comb begin
    upd_active   = 1'b0;
    idx          = 2'd0;
    upd_done_nxt = (state == UPD2);
    missed_nxt   = frame_tick && (state != IDLE);
    case (state)
      UPD0: begin upd_active = 1'b1; idx = 2'd0; end
      UPD1: begin upd_active = 1'b1; idx = 2'd1; end
      UPD2: begin upd_active = 1'b1; idx = 2'd2; end
      default: ;
    endcase
  end

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (upd_active),
    .seed  (LFSR_SEED),
    .value (lfsr)
  );

  assign h_sum  = {1'b0, horizon_off} + {8'b0, speed_q} + 11'd1;
  assign h_wrap = (h_sum >= {1'b0, SCREEN_W}) ? h_sum - {1'b0, SCREEN_W} : h_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      move_frame  <= 1'b0;
      speed_q     <= '0;
      horizon_off <= '0;
      upd_done    <= 1'b0;
      missed_tick <= 1'b0;
      for (int unsigned i = 0; i < NUM_CLOUDS; i++) begin
        cx[i] <= CLOUD_RST_X[i];
        cy[i] <= CLOUD_RST_Y[i];
      end
    end else begin
      upd_done    <= upd_done_nxt;
      missed_tick <= missed_nxt;
      if (accept) begin
        move_frame <= (div_cnt == 4'(CLOUD_DIV - 1));
        div_cnt    <= (div_cnt == 4'(CLOUD_DIV - 1)) ? '0 : div_cnt + 4'd1;
        speed_q    <= speed;
      end
      if (state == UPD0) begin
        horizon_off <= h_wrap[9:0];
      end
      if (upd_active && move_frame) begin
        if (cx[idx] == '0) begin
          cx[idx] <= SCREEN_W;
          cy[idx] <= Y_MIN + {3'b000, lfsr[6:0]};
        end else begin
          cx[idx] <= cx[idx] - 10'd1;
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) lfsr != '0);

  assign cloud0_x = cx[0];
  assign cloud1_x = cx[1];
  assign cloud2_x = cx[2];
  assign cloud0_y = cy[0];
  assign cloud1_y = cy[1];
  assign cloud2_y = cy[2];

endmodule

// File: tb/tb_cloud_scroll_ctrl.sv
// Randomized bench for cloud_scroll_ctrl: two instances (CLOUD_DIV 4 and 1)
// share stimulus and are compared against a frame-level reference model.
module tb_cloud_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       run = 1'b0;
  logic [2:0] speed = '0;

  logic [9:0] x4 [3];
  logic [9:0] y4 [3];
  logic [9:0] x1 [3];
  logic [9:0] y1 [3];
  logic [9:0] h4, h1;
  logic       done4, done1, miss4, miss1;

  always #5 clk = ~clk;

  cloud_scroll_ctrl #(.CLOUD_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .speed(speed),
    .cloud0_x(x4[0]), .cloud1_x(x4[1]), .cloud2_x(x4[2]),
    .cloud0_y(y4[0]), .cloud1_y(y4[1]), .cloud2_y(y4[2]),
    .horizon_off(h4), .upd_done(done4), .missed_tick(miss4)
  );

  cloud_scroll_ctrl #(.CLOUD_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .speed(speed),
    .cloud0_x(x1[0]), .cloud1_x(x1[1]), .cloud2_x(x1[2]),
    .cloud0_y(y1[0]), .cloud1_y(y1[1]), .cloud2_y(y1[2]),
    .horizon_off(h1), .upd_done(done1), .missed_tick(miss1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: clouds per instance, shared horizon and LFSR.
  int         divs [2] = '{4, 1};
  int         m_x [2][3];
  int         m_y [2][3];
  int         m_div [2];
  int         m_h;
  logic [7:0] m_lfsr;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_x[d]   = '{10, 100, 500};
      m_y[d]   = '{10, 100, 80};
      m_div[d] = 0;
    end
    m_h    = 0;
    m_lfsr = 8'hA5;
  endtask

  task automatic model_tick(input int sp);
    logic [7:0] l;
    bit mv;
    for (int d = 0; d < 2; d++) begin
      mv = (m_div[d] == divs[d] - 1);
      m_div[d] = mv ? 0 : m_div[d] + 1;
      l = m_lfsr;
      for (int i = 0; i < 3; i++) begin
        if (mv) begin
          if (m_x[d][i] == 0) begin
            m_x[d][i] = 640;
            m_y[d][i] = 20 + int'(l[6:0]);
          end else begin
            m_x[d][i] = m_x[d][i] - 1;
          end
        end
        l = lfsr_step(l);
      end
    end
    for (int k = 0; k < 3; k++) m_lfsr = lfsr_step(m_lfsr);
    m_h = (m_h + sp + 1) % 640;
  endtask

  function automatic logic [139:0] exp_snap();
    logic [139:0] s;
    s = '0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 3; i++) begin
        s = {s[129:0], 10'(m_x[d][i])};
        s = {s[129:0], 10'(m_y[d][i])};
      end
      s = {s[129:0], 10'(m_h)};
    end
    return s;
  endfunction

  function automatic logic [139:0] dut_snap();
    logic [139:0] s;
    s = '0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 3; i++) begin
        s = {s[129:0], (d == 0) ? x4[i] : x1[i]};
        s = {s[129:0], (d == 0) ? y4[i] : y1[i]};
      end
      s = {s[129:0], (d == 0) ? h4 : h1};
    end
    return s;
  endfunction

  // Issues one tick at a negedge, returns cycles until upd_done (-1 none,
  // -2 instances disagree) and updates the model if the tick was accepted.
  task automatic do_tick(input bit perturb, output int lat);
    int sp;
    bit acc;
    sp  = int'(speed);
    acc = run;
    lat = -1;
    frame_tick = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        frame_tick = 1'b0;
        speed = 3'($urandom);
        if (perturb) run = 1'($urandom);
      end
      if ((done4 || done1) && lat == -1) lat = (done4 === done1) ? c : -2;
    end
    if (acc) model_tick(sp);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (dut_snap() !== exp_snap()) $display("FAIL reset_state: got %h expected %h", dut_snap(), exp_snap());
    else n_pass++;
    n_checks++;
    if ({done4, done1, miss4, miss1} !== 4'b0000) $display("FAIL reset_pulses: got %b expected 0000", {done4, done1, miss4, miss1});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (dut_snap() !== exp_snap()) $display("FAIL idle_after_reset: got %h expected %h", dut_snap(), exp_snap());
    else n_pass++;
  endtask

  task automatic test_basic();
    int lat;
    run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      speed = 3'd0;
      do_tick(1'b0, lat);
      n_checks++;
      if (lat !== 4) $display("FAIL basic_latency: got %0d expected 4", lat);
      else n_pass++;
      repeat (792) @(negedge clk);
    end
    n_checks++;
    if ({x4[0], x4[1], x4[2]} !== {10'd9, 10'd99, 10'd499}) $display("FAIL basic_cloud_x: got %0d/%0d/%0d expected 9/99/499", x4[0], x4[1], x4[2]);
    else n_pass++;
    n_checks++;
    if (h4 !== 10'd4) $display("FAIL basic_horizon: got %0d expected 4", h4);
    else n_pass++;
    n_checks++;
    if (dut_snap() !== exp_snap()) $display("FAIL basic_model: got %h expected %h", dut_snap(), exp_snap());
    else n_pass++;
  endtask

  task automatic drive_horizon_to(input int target);
    int lat, step;
    run = 1'b1;
    for (int guard = 0; guard < 200 && m_h != target; guard++) begin
      step = (target - m_h + 640) % 640;
      if (step > 8) step = 8;
      speed = 3'(step - 1);
      do_tick(1'b0, lat);
    end
  endtask

  task automatic test_horizon_wrap();
    int lat;
    drive_horizon_to(636);
    n_checks++;
    if (h4 !== 10'd636) $display("FAIL horizon_setup_636: got %0d expected 636", h4);
    else n_pass++;
    speed = 3'd7;
    do_tick(1'b0, lat);
    n_checks++;
    if (h4 !== 10'd4 || h1 !== 10'd4) $display("FAIL horizon_wrap_636: got %0d/%0d expected 4", h4, h1);
    else n_pass++;
    drive_horizon_to(632);
    speed = 3'd7;
    do_tick(1'b0, lat);
    n_checks++;
    if (h4 !== 10'd0 || h1 !== 10'd0) $display("FAIL horizon_wrap_632: got %0d/%0d expected 0", h4, h1);
    else n_pass++;
    n_checks++;
    if (dut_snap() !== exp_snap()) $display("FAIL horizon_model: got %h expected %h", dut_snap(), exp_snap());
    else n_pass++;
  endtask

  task automatic test_respawn();
    int lat;
    int exp_y;
    run = 1'b1;
    for (int guard = 0; guard < 700 && m_x[1][0] != 0; guard++) do_tick(1'b0, lat);
    n_checks++;
    if (x1[0] !== 10'd0) $display("FAIL respawn_rundown: got %0d expected 0", x1[0]);
    else n_pass++;
    exp_y = 20 + int'(m_lfsr[6:0]);
    do_tick(1'b0, lat);
    n_checks++;
    if (x1[0] !== 10'd640) $display("FAIL respawn_x: got %0d expected 640", x1[0]);
    else n_pass++;
    n_checks++;
    if (y1[0] !== 10'(exp_y) || y1[0] < 10'd20 || y1[0] > 10'd147) $display("FAIL respawn_y: got %0d expected %0d", y1[0], exp_y);
    else n_pass++;
    n_checks++;
    if (dut_snap() !== exp_snap()) $display("FAIL respawn_model: got %h expected %h", dut_snap(), exp_snap());
    else n_pass++;
  endtask

  task automatic test_random();
    int lat, want;
    for (int k = 0; k < 60; k++) begin
      run   = ($urandom % 4) != 0;
      speed = 3'($urandom);
      want  = run ? 4 : -1;
      do_tick(1'b1, lat);
      n_checks++;
      if (lat !== want) $display("FAIL random_latency[%0d]: got %0d expected %0d", k, lat, want);
      else n_pass++;
      n_checks++;
      if (dut_snap() !== exp_snap()) $display("FAIL random_model[%0d]: got %h expected %h", k, dut_snap(), exp_snap());
      else n_pass++;
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int sp, misses, dones;
    run   = 1'b1;
    speed = 3'($urandom);
    sp    = int'(speed);
    misses = 0;
    dones  = 0;
    frame_tick = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) frame_tick = 1'b0;
      if (c == 2) frame_tick = 1'b1;
      if (c == 3) frame_tick = 1'b0;
      if (miss4 && miss1) misses++;
      if (done4 && done1) dones++;
    end
    model_tick(sp);
    n_checks++;
    if (misses !== 1) $display("FAIL b2b_missed: got %0d pulses expected 1", misses);
    else n_pass++;
    n_checks++;
    if (dones !== 1) $display("FAIL b2b_done: got %0d pulses expected 1", dones);
    else n_pass++;
    n_checks++;
    if (dut_snap() !== exp_snap()) $display("FAIL b2b_model: got %h expected %h", dut_snap(), exp_snap());
    else n_pass++;

    run = 1'b0;
    dones = 0;
    misses = 0;
    frame_tick = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) frame_tick = 1'b0;
      if (done4 || done1) dones++;
      if (miss4 || miss1) misses++;
    end
    n_checks++;
    if (dones !== 0 || misses !== 0) $display("FAIL paused_tick_pulses: got done=%0d miss=%0d expected 0/0", dones, misses);
    else n_pass++;
    n_checks++;
    if (dut_snap() !== exp_snap()) $display("FAIL paused_tick_model: got %h expected %h", dut_snap(), exp_snap());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat;
    run = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (dut_snap() !== exp_snap()) $display("FAIL midreset_state: got %h expected %h", dut_snap(), exp_snap());
    else n_pass++;
    n_checks++;
    if ({done4, done1, miss4, miss1} !== 4'b0000) $display("FAIL midreset_pulses: got %b expected 0000", {done4, done1, miss4, miss1});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    speed = 3'($urandom);
    do_tick(1'b0, lat);
    n_checks++;
    if (lat !== 4) $display("FAIL midreset_latency: got %0d expected 4", lat);
    else n_pass++;
    n_checks++;
    if (dut_snap() !== exp_snap()) $display("FAIL midreset_model: got %h expected %h", dut_snap(), exp_snap());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_horizon_wrap();
    test_respawn();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
